// File: rtl/score_history_mem.sv
// Per-player round-score history with DEPTH-round delayed output, random read,
// saturating running totals and winner detection. Optional undo port: define SCORE_UNDO_EN.
module score_history_mem #(
  parameter int N_PLAYERS = 2,
  parameter int SCORE_W   = 3,
  parameter int DEPTH     = 8,
  parameter int TOTAL_W   = 5,
  parameter int WIN_SCORE = 12
) (
  input  logic                           clk,
  input  logic                           Clr,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [N_PLAYERS*SCORE_W-1:0]   wr_score,
  output logic [N_PLAYERS*SCORE_W-1:0]   placar,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  input  logic [$clog2(DEPTH)-1:0]       rd_idx,
  output logic [N_PLAYERS*SCORE_W-1:0]   rd_score,
  output logic [N_PLAYERS*TOTAL_W-1:0]   total,
  output logic [N_PLAYERS-1:0]           winner,
  output logic                           game_over
`ifdef SCORE_UNDO_EN
  ,
  input  logic                           undo
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ROW_W = N_PLAYERS*SCORE_W;
  localparam logic [TOTAL_W-1:0] WIN_T = TOTAL_W'(WIN_SCORE);

  logic [ROW_W-1:0] hist [DEPTH];
  logic             accept;
  logic [N_PLAYERS*TOTAL_W-1:0] tot_add;
  logic [N_PLAYERS-1:0]         win_add;

  function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] acc,
                                                 input logic [SCORE_W-1:0] inc);
    logic [TOTAL_W:0] sum;
    sum = {1'b0, acc} + (TOTAL_W+1)'(inc);
    return sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
  endfunction

  function automatic logic [TOTAL_W-1:0] sat_sub(input logic [TOTAL_W-1:0] acc,
                                                 input logic [SCORE_W-1:0] dec);
    logic [TOTAL_W:0] diff;
    diff = {1'b0, acc} - (TOTAL_W+1)'(dec);
    return diff[TOTAL_W] ? '0 : diff[TOTAL_W-1:0];
  endfunction

  assign game_over = |winner;
  assign wr_ready  = !game_over;
  assign accept    = wr_valid && wr_ready;
  assign full      = (count == CNT_W'(DEPTH));

  always_comb begin
    tot_add = '0;
    win_add = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      tot_add[p*TOTAL_W +: TOTAL_W] = sat_add(total[p*TOTAL_W +: TOTAL_W],
                                              wr_score[p*SCORE_W +: SCORE_W]);
      win_add[p] = (tot_add[p*TOTAL_W +: TOTAL_W] >= WIN_T);
    end
  end

`ifdef SCORE_UNDO_EN
  logic [N_PLAYERS*TOTAL_W-1:0] tot_sub;
  logic [N_PLAYERS-1:0]         win_sub;
  logic                         do_undo;

  // An accepted write takes precedence; undo of an empty history is a no-op.
  assign do_undo = undo && !accept && (count != '0);

  always_comb begin
    tot_sub = '0;
    win_sub = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      tot_sub[p*TOTAL_W +: TOTAL_W] = sat_sub(total[p*TOTAL_W +: TOTAL_W],
                                              hist[0][p*SCORE_W +: SCORE_W]);
      win_sub[p] = (tot_sub[p*TOTAL_W +: TOTAL_W] >= WIN_T);
    end
  end
`endif

  // Stage p1: history shift, totals, winner and registered read port
  always_ff @(posedge clk) begin
    if (!Clr) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      placar   <= '0;
      count    <= '0;
      rd_score <= '0;
      total    <= '0;
      winner   <= '0;
    end else begin
      rd_score <= (CNT_W'(rd_idx) < count) ? hist[rd_idx] : '0;
      if (accept) begin
        for (int i = DEPTH-1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= wr_score;
        placar  <= hist[DEPTH-1];
        count   <= full ? count : count + CNT_W'(1);
        total   <= tot_add;
        winner  <= win_add;
      end
`ifdef SCORE_UNDO_EN
      else if (do_undo) begin
        for (int i = 0; i < DEPTH-1; i++) hist[i] <= hist[i+1];
        hist[DEPTH-1] <= '0;
        count  <= count - CNT_W'(1);
        total  <= tot_sub;
        winner <= win_sub;
      end
`endif
    end
  end

endmodule
